led_flash_stretcher: RTL and testbench
======================================

// Module: led_flash_stretcher
// PURPOSE
//  Output-side companion to the push-button debouncer: turns single-cycle
//  event strobes (note-on, button accepted, etc.) into human-visible LED
//  flashes of fixed minimum ON time, separated by a fixed minimum OFF gap.
//  Bursts of events are counted in a saturating pending counter and replayed
//  as distinct flashes, so no event is visually merged or lost below saturation.
// PARAMETERS
//  ON_MSB   19  ON counter MSB; flash lasts exactly 2^(ON_MSB+1) CLK cycles (~21 ms @50 MHz)
//  GAP_MSB  19  GAP counter MSB; dark gap lasts exactly 2^(GAP_MSB+1) CLK cycles
//  PEND_W   4   pending-event counter width; saturates at 2^PEND_W-1
// PORTS
//  CLK       in   1       system clock, all logic on posedge
//  RST_N     in   1       asynchronous active-low reset
//  EVENT_IN  in   1       event strobe, 1 = one event per high cycle
//  CLR_OVF   in   1       synchronous clear of OVERFLOW
//  LED_OUT   out  1       registered LED drive, 1 = lit
//  BUSY      out  1       1 when state != IDLE
//  PENDING   out  PEND_W  queued events not yet flashed
//  OVERFLOW  out  1       sticky: event arrived while PENDING saturated
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE, counters=0, LED_OUT=0, BUSY=0,
//   PENDING=0, OVERFLOW=0. Reset mid-flash aborts immediately; queue is lost.
//  States: IDLE -> ON -> GAP -> (ON | IDLE).
//  start = (IDLE, or GAP on its last cycle) and (PENDING!=0 or EVENT_IN).
//   Next state ON, ON counter loaded to 0.
//  IDLE: no start -> stay IDLE.
//  ON: counter increments each cycle; on terminal count (all ones) -> GAP,
//   GAP counter loaded to 0. ON state lasts exactly 2^(ON_MSB+1) cycles.
//  GAP: counter increments; on terminal count, start -> ON, else -> IDLE.
//   Exactly 2^(GAP_MSB+1) cycles. ON always followed by a full GAP.
//  LED_OUT = registered (next_state==ON): high on the cycle after the edge
//   that samples the starting EVENT_IN; one-cycle latency from IDLE.
//  BUSY = registered (next_state!=IDLE), same timing as LED_OUT.
//  PENDING update per edge (simultaneous events resolved here):
//   start & PENDING==0       : EVENT_IN consumed directly, PENDING stays 0
//   start & PENDING!=0       : PENDING <= PENDING-1+EVENT_IN (net 0 if both)
//   no start                 : PENDING <= PENDING+EVENT_IN, saturating
//  Saturation: EVENT_IN while PENDING==max and no start -> PENDING holds,
//   OVERFLOW<=1. OVERFLOW cleared only by CLR_OVF or reset; if CLR_OVF and
//   a new overflow coincide, OVERFLOW stays 1 (set wins).
//  Events during ON or GAP are never dropped below saturation; no
//   retriggering: an event never extends the current flash.
//  All outputs glitch-free registers; no combinational path EVENT_IN->LED_OUT.
// TESTING  (bench params: ON_MSB=2 -> 8 cycles, GAP_MSB=1 -> 4 cycles, PEND_W=2)
//  1 reset, idle, single EVENT_IN pulse -> LED_OUT high cycles 1..8 after
//    sampling edge, low >=4 cycles, BUSY falls after 12 cycles, PENDING=0
//  2 3 back-to-back EVENT_IN pulses from IDLE -> PENDING 0,1,2; three 8-cycle
//    flashes each separated by 4-cycle gap; total BUSY = 36 cycles
//  3 EVENT_IN held 6 cycles from IDLE -> PENDING saturates at 3, OVERFLOW=1
//    stays after queue drains; CLR_OVF pulse -> OVERFLOW=0 next cycle
//  4 EVENT_IN on last GAP cycle with PENDING=1 -> flash starts, PENDING stays 1
//  5 RST_N low mid-ON with PENDING=2 -> LED_OUT, BUSY, PENDING, OVERFLOW 0
//    immediately (async); no flash resumes after release
//  6 CLR_OVF coincident with overflowing EVENT_IN -> OVERFLOW remains 1

Source files
------------

// File: rtl/led_flash_stretcher.sv
// LED flash stretcher: turns single-cycle event strobes into fixed-length
// LED flashes separated by fixed dark gaps.
//
// Ports:
//   CLK       system clock, posedge
//   RST_N     async active-low reset
//   EVENT_IN  event strobe, one event per high cycle
//   CLR_OVF   synchronous clear of OVERFLOW
//   LED_OUT   registered LED drive, 1 = lit
//   BUSY      registered, 1 while not idle
//   PENDING   queued events not yet flashed (saturating)
//   OVERFLOW  sticky, set when an event hits a saturated queue
module led_flash_stretcher #(
  parameter int ON_MSB  = 19,
  parameter int GAP_MSB = 19,
  parameter int PEND_W  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EVENT_IN,
  input  logic              CLR_OVF,
  output logic              LED_OUT,
  output logic              BUSY,
  output logic [PEND_W-1:0] PENDING,
  output logic              OVERFLOW
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [ON_MSB:0]  ON_ONE  = 1;
  localparam logic [GAP_MSB:0] GAP_ONE = 1;
  localparam logic [PEND_W-1:0] P_ONE  = 1;

  state_t state;
  state_t next_state;

  logic [ON_MSB:0]  on_cnt;
  logic [GAP_MSB:0] gap_cnt;

  logic on_last;
  logic gap_last;
  logic pend_nz;
  logic pend_max;
  logic start;
  logic ovf_set;
  logic led_d;
  logic busy_d;

  logic [PEND_W-1:0] ev_w;

  assign on_last  = (state == S_ON) && (&on_cnt);
  assign gap_last = (state == S_GAP) && (&gap_cnt);
  assign pend_nz  = |PENDING;
  assign pend_max = &PENDING;
  assign ev_w     = {{(PEND_W-1){1'b0}}, EVENT_IN};

  // A new flash may begin from idle or seamlessly after a full gap.
  assign start = ((state == S_IDLE) || gap_last)
               && (pend_nz || EVENT_IN);

  assign ovf_set = EVENT_IN && pend_max && !start;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_ON;
      end
      S_ON: begin
        if (on_last) next_state = S_GAP;
      end
      S_GAP: begin
        if (gap_last) begin
          next_state = start ? S_ON : S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    led_d  = (next_state == S_ON);
    busy_d = (next_state != S_IDLE);
  end

  // Counters reset whenever their state is not active, so each
  // entry into ON or GAP begins at zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      on_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      on_cnt  <= (state == S_ON) ? on_cnt + ON_ONE : '0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_ONE : '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LED_OUT <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      LED_OUT <= led_d;
      BUSY    <= busy_d;
    end
  end

  // A start with an empty queue consumes EVENT_IN directly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PENDING <= '0;
    end else if (start) begin
      if (pend_nz) PENDING <= PENDING - P_ONE + ev_w;
    end else if (EVENT_IN && !pend_max) begin
      PENDING <= PENDING + P_ONE;
    end
  end

  // Set wins over a coincident clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW <= 1'b0;
    end else begin
      OVERFLOW <= ovf_set || (OVERFLOW && !CLR_OVF);
    end
  end

endmodule

// File: tb/tb_led_flash_stretcher.sv
// Testbench for led_flash_stretcher: directed scenarios plus random
// strobes compared against a flash-timeline reference model.
module tb_led_flash_stretcher;

  localparam int ON_MSB  = 2;
  localparam int GAP_MSB = 1;
  localparam int PEND_W  = 2;
  localparam int ON_LEN  = 1 << (ON_MSB + 1);
  localparam int GAP_LEN = 1 << (GAP_MSB + 1);
  localparam int PERIOD  = ON_LEN + GAP_LEN;
  localparam int PMAX    = (1 << PEND_W) - 1;

  logic              CLK;
  logic              RST_N;
  logic              EVENT_IN;
  logic              CLR_OVF;
  logic              LED_OUT;
  logic              BUSY;
  logic [PEND_W-1:0] PENDING;
  logic              OVERFLOW;

  int errors = 0;
  int checks = 0;

  // Reference: m_t is the cycle index inside the current
  // flash+gap period (-1 when idle).
  int m_t    = -1;
  int m_pend = 0;
  int m_ovf  = 0;

  int led_cnt;
  int busy_cnt;

  led_flash_stretcher #(
    .ON_MSB (ON_MSB),
    .GAP_MSB(GAP_MSB),
    .PEND_W (PEND_W)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EVENT_IN(EVENT_IN),
    .CLR_OVF (CLR_OVF),
    .LED_OUT (LED_OUT),
    .BUSY    (BUSY),
    .PENDING (PENDING),
    .OVERFLOW(OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t    = -1;
    m_pend = 0;
    m_ovf  = 0;
  endtask

  task automatic model_step(input bit ev, input bit clr);
    bit st;
    bit oset;
    st   = ((m_t < 0) || (m_t == PERIOD - 1)) && ((m_pend != 0) || ev);
    oset = 0;
    if (st) begin
      if (m_pend != 0) m_pend = m_pend - 1 + int'(ev);
    end else if (ev) begin
      if (m_pend == PMAX) oset = 1;
      else m_pend++;
    end
    m_ovf = (oset || (m_ovf != 0 && !clr)) ? 1 : 0;
    if (st) m_t = 0;
    else if (m_t == PERIOD - 1) m_t = -1;
    else if (m_t >= 0) m_t++;
  endtask

  task automatic compare_all(string tag);
    int mled;
    int mbusy;
    mled  = (m_t >= 0 && m_t < ON_LEN) ? 1 : 0;
    mbusy = (m_t >= 0) ? 1 : 0;
    check({tag, ".led"}, 32'(LED_OUT), 32'(mled));
    check({tag, ".busy"}, 32'(BUSY), 32'(mbusy));
    check({tag, ".pend"}, 32'(PENDING), 32'(m_pend));
    check({tag, ".ovf"}, 32'(OVERFLOW), 32'(m_ovf));
  endtask

  task automatic step(string tag, input bit ev, input bit clr);
    EVENT_IN = ev;
    CLR_OVF  = clr;
    @(posedge CLK);
    model_step(ev, clr);
    #1;
    compare_all(tag);
    EVENT_IN = 1'b0;
    CLR_OVF  = 1'b0;
    if (LED_OUT) led_cnt++;
    if (BUSY) busy_cnt++;
  endtask

  initial begin
    int n;
    RST_N    = 1'b0;
    EVENT_IN = 1'b0;
    CLR_OVF  = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    compare_all("reset");
    RST_N = 1'b1;

    // 1: single pulse from idle
    led_cnt  = 0;
    busy_cnt = 0;
    step("s1", 1, 0);
    check("s1_led_first", 32'(LED_OUT), 1);
    for (int i = 0; i < 20; i++) step("s1", 0, 0);
    check("s1_led_len", led_cnt, ON_LEN);
    check("s1_busy_len", busy_cnt, PERIOD);

    // 2: three back-to-back pulses
    led_cnt  = 0;
    busy_cnt = 0;
    step("s2", 1, 0);
    check("s2_p0", 32'(PENDING), 0);
    step("s2", 1, 0);
    check("s2_p1", 32'(PENDING), 1);
    step("s2", 1, 0);
    check("s2_p2", 32'(PENDING), 2);
    for (int i = 0; i < 45; i++) step("s2", 0, 0);
    check("s2_busy_len", busy_cnt, 3 * PERIOD);
    check("s2_led_len", led_cnt, 3 * ON_LEN);

    // 3: held event saturates queue
    for (int i = 0; i < 6; i++) step("s3", 1, 0);
    check("s3_sat", 32'(PENDING), PMAX);
    check("s3_ovf", 32'(OVERFLOW), 1);
    for (int i = 0; i < 60; i++) step("s3", 0, 0);
    check("s3_drained", 32'(PENDING), 0);
    check("s3_ovf_sticky", 32'(OVERFLOW), 1);
    step("s3", 0, 1);
    check("s3_ovf_clr", 32'(OVERFLOW), 0);

    // 4: event on last gap cycle with one pending
    step("s4", 1, 0);
    step("s4", 1, 0);
    n = 0;
    while (m_t != PERIOD - 1 && n < 50) begin
      step("s4", 0, 0);
      n++;
    end
    check("s4_reach_gap_end", 32'(n < 50), 1);
    step("s4", 1, 0);
    check("s4_pend", 32'(PENDING), 1);
    check("s4_led", 32'(LED_OUT), 1);
    for (int i = 0; i < 40; i++) step("s4", 0, 0);

    // 5: async reset mid-flash
    for (int i = 0; i < 3; i++) step("s5", 1, 0);
    step("s5", 0, 0);
    check("s5_pre_pend", 32'(PENDING), 2);
    check("s5_pre_led", 32'(LED_OUT), 1);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    compare_all("s5_async");
    @(posedge CLK);
    #1;
    compare_all("s5_hold");
    RST_N    = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) step("s5_after", 0, 0);
    check("s5_no_resume", busy_cnt, 0);

    // 6: clear coincident with overflow
    for (int i = 0; i < 4; i++) step("s6", 1, 0);
    check("s6_sat", 32'(PENDING), PMAX);
    step("s6", 1, 1);
    check("s6_set_wins", 32'(OVERFLOW), 1);
    for (int i = 0; i < 60; i++) step("s6", 0, 0);
    step("s6", 0, 1);

    // random strobes
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
